layer_cmd_sched: RTL and testbench

// - Layer sequencer in front of the global-buffer controller: queues per-layer descriptors from the host/CSR path.
// - Issues one 32-bit computation command per layer with the data/weight init addresses.
// - Waits for that layer's done, then moves to the next layer. Raises net_done after the descriptor flagged last.

---
 rtl/mbn_sched_pkg.sv | 45 ++++
 rtl/sched_desc_fifo.sv | 65 ++++++
 rtl/layer_cmd_sched.sv | 174 +++++++++++++++++
 tb/tb_layer_cmd_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbn_sched_pkg.sv
// Shared types for the layer command scheduler: computation types, the
// per-layer descriptor record, FSM state encoding and the command packer.
package mbn_sched_pkg;

    // Address width carried inside a stored descriptor. A wider top-level AW
    // is truncated to this width when the descriptor is queued.
    localparam int SCHED_AW = 32;
    localparam int CHN_W    = 28;

    typedef enum logic [2:0] {
        DWC = 3'd0,
        PWC = 3'd1,
        CON = 3'd2,
        FC  = 3'd3,
        PO  = 3'd4
    } comp_type_e;

    // The type is kept as raw bits so that codes 5..7 can be stored and rejected.
    typedef struct packed {
        logic [2:0]          ctype;
        logic [CHN_W-1:0]    chn;
        logic [SCHED_AW-1:0] daddr;
        logic [SCHED_AW-1:0] waddr;
        logic                last;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        NEXT
    } sched_state_e;

    function automatic logic [31:0] pack_cmd(input logic             en,
                                             input logic [2:0]       ctype,
                                             input logic [CHN_W-1:0] chn);
        return {en, ctype, chn};
    endfunction

    function automatic logic type_valid(input logic [2:0] ctype);
        return (ctype <= PO);
    endfunction

endpackage

// File: rtl/sched_desc_fifo.sv
// Synchronous descriptor FIFO for the layer scheduler. Push is refused when
// full and pop is refused when empty. The flush input discards all
// entries in one cycle.
module sched_desc_fifo
    import mbn_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  push,
    input  desc_t wdata,
    input  logic  pop,
    output desc_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int PW = $clog2(DEPTH);

    desc_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Write accepted descriptors into storage.
    // NOTE: the storage array has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop leaves count unchanged.
    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/layer_cmd_sched.sv
// Layer sequencer in front of the global-buffer controller. It queues
// per-layer descriptors and issues one computation command per layer. It
// then waits for that layer's done before moving on, and raises net_done
// once the descriptor flagged last has completed.
// Optional watchdog: define SCHED_TIMEOUT_EN to abort a layer whose done
// never arrives. Without it, timeout is tied low.
module layer_cmd_sched
    import mbn_sched_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 8,
    parameter int TO_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          desc_valid,
    output logic          desc_ready,
    input  logic [2:0]    desc_type,
    input  logic [27:0]   desc_chn,
    input  logic [AW-1:0] desc_daddr,
    input  logic [AW-1:0] desc_waddr,
    input  logic          desc_last,
    input  logic          run,
    output logic [31:0]   comp_cmd,
    output logic [AW-1:0] data_init_addr,
    output logic [AW-1:0] weight_init_addr,
    input  logic          layer_done,
    output logic          busy,
    output logic [7:0]    layer_idx,
    output logic          net_done,
    output logic          bad_cmd,
    output logic          timeout
);

    sched_state_e state;
    sched_state_e state_nxt;
    desc_t        wdata;
    desc_t        head;
    desc_t        cur;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         to_hit;
    logic [7:0]   idx;

    assign wdata = '{ctype: desc_type,
                     chn:   desc_chn,
                     daddr: SCHED_AW'(desc_daddr),
                     waddr: SCHED_AW'(desc_waddr),
                     last:  desc_last};

    sched_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (to_hit),
        .push  (desc_valid),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Watchdog: cleared while issuing, counts every cycle spent waiting for done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if (state == WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // A done arriving in the expiry cycle takes priority over the abort.
    assign to_hit = (state == WAIT) && (&to_cnt) && !layer_done;
`else
    assign to_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the FETCH decision looks at the queue head being popped.
    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (run && !fifo_empty) state_nxt = FETCH;
            FETCH: state_nxt = type_valid(head.ctype) ? ISSUE : NEXT;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (layer_done) begin
                    state_nxt = NEXT;
                end else if (to_hit) begin
                    state_nxt = IDLE;
                end
            end
            NEXT: begin
                if (cur.last) begin
                    state_nxt = IDLE;
                end else if (!fifo_empty) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Current-layer descriptor, loaded as the head is popped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur <= '0;
        end else if (state == FETCH) begin
            cur <= head;
        end
    end

    // Completed-layer counter: cleared on an accepted run, bumped on each done while waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if ((state == IDLE) && run && !fifo_empty) begin
            idx <= '0;
        end else if ((state == WAIT) && layer_done) begin
            idx <= idx + 8'd1;
        end
    end

    // Per-state outputs: command, addresses, pop strobe and event pulses.
    always_comb begin
        comp_cmd         = '0;
        data_init_addr   = '0;
        weight_init_addr = '0;
        pop              = 1'b0;
        bad_cmd          = 1'b0;
        net_done         = 1'b0;
        unique case (state)
            FETCH: begin
                pop     = 1'b1;
                bad_cmd = !type_valid(head.ctype);
            end
            ISSUE: begin
                comp_cmd         = pack_cmd(1'b1, cur.ctype, cur.chn);
                data_init_addr   = AW'(cur.daddr);
                weight_init_addr = AW'(cur.waddr);
            end
            WAIT: begin
                comp_cmd         = pack_cmd(1'b0, cur.ctype, cur.chn);
                data_init_addr   = AW'(cur.daddr);
                weight_init_addr = AW'(cur.waddr);
            end
            NEXT:    net_done = cur.last;
            default: ;
        endcase
    end

    assign desc_ready = !fifo_full;
    assign busy       = (state != IDLE);
    assign layer_idx  = idx;
    assign timeout    = to_hit;

endmodule

// File: tb/tb_layer_cmd_sched.sv
// Scoreboard bench for layer_cmd_sched. Stimulus pushes the expected
// ISSUE / BAD / NET / TIMEOUT events into a queue. A monitor pops and
// compares an event whenever the DUT pulses one of those outputs.
// Define SCHED_TIMEOUT_EN to build with the watchdog (TO_W=4).
module tb_layer_cmd_sched;
    import mbn_sched_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 8;
`ifdef SCHED_TIMEOUT_EN
    localparam int TO_W  = 4;
`else
    localparam int TO_W  = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [2:0]    desc_type = '0;
    logic [27:0]   desc_chn = '0;
    logic [AW-1:0] desc_daddr = '0;
    logic [AW-1:0] desc_waddr = '0;
    logic          desc_last = 1'b0;
    logic          run = 1'b0;
    logic [31:0]   comp_cmd;
    logic [AW-1:0] data_init_addr;
    logic [AW-1:0] weight_init_addr;
    logic          layer_done = 1'b0;
    logic          busy;
    logic [7:0]    layer_idx;
    logic          net_done;
    logic          bad_cmd;
    logic          timeout;

    layer_cmd_sched #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .TO_W  (TO_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .desc_valid       (desc_valid),
        .desc_ready       (desc_ready),
        .desc_type        (desc_type),
        .desc_chn         (desc_chn),
        .desc_daddr       (desc_daddr),
        .desc_waddr       (desc_waddr),
        .desc_last        (desc_last),
        .run              (run),
        .comp_cmd         (comp_cmd),
        .data_init_addr   (data_init_addr),
        .weight_init_addr (weight_init_addr),
        .layer_done       (layer_done),
        .busy             (busy),
        .layer_idx        (layer_idx),
        .net_done         (net_done),
        .bad_cmd          (bad_cmd),
        .timeout          (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef enum int {EV_ISSUE, EV_BAD, EV_NET, EV_TO} ev_kind_e;
    typedef struct {
        ev_kind_e      kind;
        logic [31:0]   cmd;
        logic [AW-1:0] daddr;
        logic [AW-1:0] waddr;
        logic [7:0]    idx;
    } ev_t;

    ev_t exp_q[$];
    int  issue_cyc[$];
    int  to_cyc = 0;
    int  bad_cnt = 0;
    int  to_cnt = 0;
    int  model_idx = 0;
    bit  auto_done = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input ev_kind_e k, input logic [31:0] cmd,
                           input logic [AW-1:0] da, input logic [AW-1:0] wa, input int i);
        ev_t e;
        e.kind = k; e.cmd = cmd; e.daddr = da; e.waddr = wa; e.idx = i[7:0];
        exp_q.push_back(e);
    endtask

    // Expected events for one descriptor of a network that runs to completion.
    task automatic sb_model(input logic [2:0] t, input logic [27:0] chn,
                            input logic [AW-1:0] da, input logic [AW-1:0] wa, input logic last);
        if (t > 3'd4) begin
            sb_push(EV_BAD, '0, '0, '0, model_idx);
        end else begin
            sb_push(EV_ISSUE, {1'b1, t, chn}, da, wa, model_idx);
            model_idx++;
        end
        if (last) begin
            sb_push(EV_NET, '0, '0, '0, model_idx);
            model_idx = 0;
        end
    endtask

    task automatic push_desc(input logic [2:0] t, input logic [27:0] chn,
                             input logic [AW-1:0] da, input logic [AW-1:0] wa,
                             input logic last, input bit model);
        int guard = 0;
        desc_valid = 1'b1; desc_type = t; desc_chn = chn;
        desc_daddr = da; desc_waddr = wa; desc_last = last;
        while (!desc_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("push_ready", desc_ready, 1);
        tick();
        desc_valid = 1'b0;
        if (model) sb_model(t, chn, da, wa, last);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_net(input int exp_idx);
        int guard = 0;
        while (!net_done && guard < 400) begin
            tick();
            guard++;
        end
        check("net_done_reached", net_done, 1);
        check("net_layer_idx", layer_idx, exp_idx);
        check("busy_at_net", busy, 1);
        tick();
        check("busy_after_net", busy, 0);
    endtask

    // Monitor: pops one expected event per DUT pulse and checks the WAIT hold.
    task automatic take(input ev_kind_e k);
        ev_t e;
        check("sb_has_event", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ev_kind", e.kind, k);
            check("ev_layer_idx", layer_idx, e.idx);
            if (k == EV_ISSUE) begin
                check("issue_cmd", comp_cmd, e.cmd);
                check("issue_daddr", data_init_addr, e.daddr);
                check("issue_waddr", weight_init_addr, e.waddr);
            end
        end
    endtask

    initial begin
        bit            hold;
        logic [31:0]   hcmd;
        logic [AW-1:0] hda;
        logic [AW-1:0] hwa;
        hold = 1'b0;
        hcmd = '0; hda = '0; hwa = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("wait_cmd", comp_cmd, {1'b0, hcmd[30:0]});
                check("wait_daddr", data_init_addr, hda);
                check("wait_waddr", weight_init_addr, hwa);
                hold = 1'b0;
            end
            if (comp_cmd[31]) begin
                issue_cyc.push_back(cyc);
                take(EV_ISSUE);
                hold = 1'b1; hcmd = comp_cmd; hda = data_init_addr; hwa = weight_init_addr;
            end
            if (bad_cmd) begin
                bad_cnt++;
                take(EV_BAD);
            end
            if (net_done) take(EV_NET);
            if (timeout) begin
                to_cnt++;
                to_cyc = cyc;
                take(EV_TO);
            end
        end
    end

    // Buffer-controller model: done pulse 5 cycles after each issue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && auto_done && comp_cmd[31]) begin
                repeat (5) @(posedge clk);
                #1 layer_done = 1'b1;
                @(posedge clk);
                #1 layer_done = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_comp_cmd"}, comp_cmd, 0);
        check({tag, "_daddr"}, data_init_addr, 0);
        check({tag, "_waddr"}, weight_init_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_layer_idx"}, layer_idx, 0);
        check({tag, "_net_done"}, net_done, 0);
        check({tag, "_bad_cmd"}, bad_cmd, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_desc_ready"}, desc_ready, 1);
    endtask

    initial begin
        int run_cyc;
        int k;
        int guard;

        // Reset state
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Run with an empty queue is ignored
        pulse_run();
        for (int i = 0; i < 4; i++) begin
            check("empty_run_busy", busy, 0);
            check("empty_run_cmd", comp_cmd, 0);
            tick();
        end

        // Three-layer network, latency and index progression
        issue_cyc.delete();
        push_desc(3'd0, 28'h0000010, 32'h0000_1000, 32'h0000_8000, 1'b0, 1'b1);
        push_desc(3'd1, 28'h0000020, 32'h0000_2000, 32'h0000_9000, 1'b0, 1'b1);
        push_desc(3'd2, 28'hABCDEF1, 32'hDEAD_0000, 32'hBEEF_0000, 1'b1, 1'b1);
        run_cyc = cyc;
        pulse_run();
        wait_net(3);
        check("three_issues", issue_cyc.size(), 3);
        if (issue_cyc.size() == 3) begin
            check("run_to_issue", issue_cyc[0] - run_cyc, 2);
            check("issue_gap", issue_cyc[1] - issue_cyc[0], 8);
        end

        // Fill the queue, hold-off while full, pop then push refills it
        for (int i = 0; i < 8; i++) begin
            push_desc(3'(i % 5), 28'(i + 1), 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                      i == 7, 1'b1);
        end
        check("full_ready", desc_ready, 0);
        desc_valid = 1'b1; desc_type = 3'd3; desc_chn = 28'h0000099;
        desc_daddr = 32'h3000_0009; desc_waddr = 32'h4000_0009; desc_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_holdoff", desc_ready, 0);
        end
        desc_valid = 1'b0;
        pulse_run();
        check("ready_in_fetch", desc_ready, 0);
        tick();
        check("ready_after_pop", desc_ready, 1);
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
        sb_model(3'd3, 28'h0000099, 32'h3000_0009, 32'h4000_0009, 1'b1);
        check("refull_ready", desc_ready, 0);
        wait_net(8);
        pulse_run();
        wait_net(1);

        // Invalid type between two valid layers
        issue_cyc.delete();
        k = bad_cnt;
        push_desc(3'd1, 28'h0000111, 32'h0000_A000, 32'h0000_B000, 1'b0, 1'b1);
        push_desc(3'd6, 28'h0000222, 32'h0000_C000, 32'h0000_D000, 1'b0, 1'b1);
        push_desc(3'd3, 28'h0000333, 32'h0000_E000, 32'h0000_F000, 1'b1, 1'b1);
        pulse_run();
        wait_net(2);
        check("bad_pulses", bad_cnt - k, 1);
        check("bad_issues", issue_cyc.size(), 2);

        // Queue runs dry before the last flag: stall in NEXT, resume on push
        issue_cyc.delete();
        push_desc(3'd2, 28'h0000444, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b1);
        pulse_run();
        guard = 0;
        while (layer_idx != 8'd1 && guard < 100) begin
            tick();
            guard++;
        end
        check("stall_idx", layer_idx, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_busy", busy, 1);
            check("stall_cmd", comp_cmd, 0);
            tick();
        end
        k = cyc;
        push_desc(3'd0, 28'h0000555, 32'h0000_3333, 32'h0000_4444, 1'b1, 1'b1);
        wait_net(2);
        check("stall_issues", issue_cyc.size(), 2);
        if (issue_cyc.size() == 2) check("push_to_issue", issue_cyc[1] - k, 3);

        auto_done = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        // Watchdog abort with the remaining queue flushed
        issue_cyc.delete();
        k = to_cnt;
        push_desc(3'd4, 28'h0000666, 32'h0000_5555, 32'h0000_6666, 1'b0, 1'b0);
        push_desc(3'd1, 28'h0000777, 32'h0000_7777, 32'h0000_8888, 1'b1, 1'b0);
        sb_push(EV_ISSUE, {1'b1, 3'd4, 28'h0000666}, 32'h0000_5555, 32'h0000_6666, 0);
        sb_push(EV_TO, '0, '0, '0, 0);
        pulse_run();
        guard = 0;
        while (to_cnt == k && guard < 100) begin
            tick();
            guard++;
        end
        check("timeout_seen", to_cnt - k, 1);
        if (issue_cyc.size() == 1) check("timeout_latency", to_cyc - issue_cyc[0], 16);
        tick();
        check("timeout_busy", busy, 0);
        check("timeout_ready", desc_ready, 1);
        pulse_run();
        for (int i = 0; i < 3; i++) begin
            check("flushed_busy", busy, 0);
            tick();
        end
`endif

        // Reset in the middle of a layer
        push_desc(3'd2, 28'h0000888, 32'h0000_9999, 32'h0000_AAAA, 1'b1, 1'b0);
        push_desc(3'd3, 28'h0000999, 32'h0000_BBBB, 32'h0000_CCCC, 1'b1, 1'b0);
        sb_push(EV_ISSUE, {1'b1, 3'd2, 28'h0000888}, 32'h0000_9999, 32'h0000_AAAA, 0);
        pulse_run();
`ifdef SCHED_TIMEOUT_EN
        repeat (6) tick();
`else
        for (int i = 0; i < 20; i++) begin
            check("no_timeout", timeout, 0);
            tick();
        end
`endif
        check("mid_layer_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check_idle_outputs("mid_reset");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_run();
        for (int i = 0; i < 3; i++) begin
            check("lost_queue_busy", busy, 0);
            tick();
        end
        auto_done = 1'b1;

        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
